// File: rtl/perf_pkg.sv
// Shared constants, state type and sizing helper for the performance counter unit.
// The optional shadow bank is enabled with the PERF_SNAPSHOT_EN macro.
package perf_pkg;

  localparam int unsigned CNT_CYCLES  = 0;
  localparam int unsigned CNT_INST    = 1;
  localparam int unsigned CNT_CH_BASE = 2;
  localparam int unsigned CNT_PER_CH  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } perfState_e;

  function automatic int unsigned num_counters(input int unsigned numCh);
    return CNT_CH_BASE + CNT_PER_CH * numCh;
  endfunction

endpackage

// File: rtl/perf_ctr_cell.sv
// Single event counter with synchronous clear, saturate-or-wrap overflow and a sticky
// overflow flag.
module perf_ctr_cell #(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf   <= 1'b1;
        count <= SATURATE ? count : '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle, instruction and per-cache event counters with a registered read port.
// Define PERF_SNAPSHOT_EN to build the shadow bank read through rd_addr MSB.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              retire,
  input  logic              halt,
  input  logic [NUM_CH-1:0] cache_req,
  input  logic [NUM_CH-1:0] cache_hit,
  input  logic [NUM_CH-1:0] cache_stall,
  input  logic              snap,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              running,
  output logic              frozen,
  output logic              ovf_any,
  output logic              proto_err
);

  localparam int unsigned NUM_CNT = num_counters(NUM_CH);

  perfState_e        state;
  logic [NUM_CNT-1:0] incVec;
  logic [NUM_CNT-1:0] ovfVec;
  logic [CNT_W-1:0]   cntVal [NUM_CNT];
  logic [ADDR_W-1:0]  rdIdx;
  logic               rdBank;
  logic [CNT_W-1:0]   rdMux;
  logic               rdMiss;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= IDLE;
      proto_err <= 1'b0;
    end else begin
      if (state == RUN && |(cache_hit & ~cache_req)) proto_err <= 1'b1;
      // start has priority over a coincident halt while idle
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (halt) state <= FROZEN;
        FROZEN:  state <= FROZEN;
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign frozen  = (state == FROZEN);
  assign ovf_any = |ovfVec;

  always_comb begin
    incVec = '0;
    if (state == RUN) begin
      incVec[CNT_CYCLES] = 1'b1;
      incVec[CNT_INST]   = retire;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        incVec[CNT_CH_BASE + CNT_PER_CH * c]     = cache_req[c];
        incVec[CNT_CH_BASE + CNT_PER_CH * c + 1] = cache_hit[c] & cache_req[c];
        incVec[CNT_CH_BASE + CNT_PER_CH * c + 2] = cache_stall[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gCell
    perf_ctr_cell #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) uCell (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (incVec[g]),
      .clr  (clear),
      .count(cntVal[g]),
      .ovf  (ovfVec[g])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow [NUM_CNT];

  // Shadow survives clear; a coincident clear still captures the pre-clear values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (snap && (state == RUN || state == FROZEN)) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) shadow[i] <= cntVal[i];
    end
  end
`else
  logic unusedSnap;
  assign unusedSnap = snap;
`endif

  assign rdIdx  = rd_addr[ADDR_W-1:0];
  assign rdBank = rd_addr[ADDR_W];

  always_comb begin
    rdMux  = '0;
    rdMiss = 1'b1;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rdIdx == ADDR_W'(i)) begin
        if (!rdBank) begin
          rdMux  = cntVal[i];
          rdMiss = 1'b0;
        end
`ifdef PERF_SNAPSHOT_EN
        else begin
          rdMux  = shadow[i];
          rdMiss = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & rdMiss;
      if (rd_en) rd_data <= rdMux;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: one 32-bit instance and two 4-bit instances (saturate, wrap)
// share stimulus and are checked against an unbounded-count reference model.
module tb_perf_counter_unit;

  localparam int NCNT = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, clear, retire, halt, snap, rd_en;
  logic [1:0]  cacheReq, cacheHit, cacheStall;
  logic [5:0]  rdAddr;
  logic [31:0] rdDataA;
  logic [3:0]  rdDataB, rdDataC;
  logic [2:0]  rdValid, rdErr, runningV, frozenV, ovfV, protoV;

  int vectors = 0;
  int miscompares = 0;

  // Model: event counts since last clear, unbounded; each DUT width is applied on readout.
  longint unsigned n       [NCNT];
  longint unsigned shadowN [NCNT];
  int              mState;  // 0 idle, 1 run, 2 frozen
  bit              mProto;

  always #5 clk = ~clk;

  perf_counter_unit #(.NUM_CH(2), .CNT_W(32), .SATURATE(1'b1), .ADDR_W(5)) uDutA (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .retire(retire), .halt(halt),
    .cache_req(cacheReq), .cache_hit(cacheHit), .cache_stall(cacheStall), .snap(snap),
    .rd_en(rd_en), .rd_addr(rdAddr), .rd_data(rdDataA), .rd_valid(rdValid[0]),
    .rd_err(rdErr[0]), .running(runningV[0]), .frozen(frozenV[0]), .ovf_any(ovfV[0]),
    .proto_err(protoV[0])
  );

  perf_counter_unit #(.NUM_CH(2), .CNT_W(4), .SATURATE(1'b1), .ADDR_W(5)) uDutB (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .retire(retire), .halt(halt),
    .cache_req(cacheReq), .cache_hit(cacheHit), .cache_stall(cacheStall), .snap(snap),
    .rd_en(rd_en), .rd_addr(rdAddr), .rd_data(rdDataB), .rd_valid(rdValid[1]),
    .rd_err(rdErr[1]), .running(runningV[1]), .frozen(frozenV[1]), .ovf_any(ovfV[1]),
    .proto_err(protoV[1])
  );

  perf_counter_unit #(.NUM_CH(2), .CNT_W(4), .SATURATE(1'b0), .ADDR_W(5)) uDutC (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .retire(retire), .halt(halt),
    .cache_req(cacheReq), .cache_hit(cacheHit), .cache_stall(cacheStall), .snap(snap),
    .rd_en(rd_en), .rd_addr(rdAddr), .rd_data(rdDataC), .rd_valid(rdValid[2]),
    .rd_err(rdErr[2]), .running(runningV[2]), .frozen(frozenV[2]), .ovf_any(ovfV[2]),
    .proto_err(protoV[2])
  );

  function automatic int widthOf(input int d);
    return (d == 0) ? 32 : 4;
  endfunction

  function automatic bit satOf(input int d);
    return (d != 2);
  endfunction

  function automatic logic [31:0] fit(input longint unsigned cnt, input int d);
    longint unsigned lim = 64'd1 << widthOf(d);
    if (cnt < lim) return 32'(cnt);
    return satOf(d) ? 32'(lim - 1) : 32'(cnt % lim);
  endfunction

  function automatic logic anyOvf(input int d);
    longint unsigned lim = 64'd1 << widthOf(d);
    for (int i = 0; i < NCNT; i++) if (n[i] >= lim) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void expRead(input int d, output logic [31:0] data, output logic err);
    int idx = int'(rdAddr[4:0]);
    data = '0;
    err  = 1'b1;
    if (idx < NCNT) begin
      if (!rdAddr[5]) begin
        data = fit(n[idx], d);
        err  = 1'b0;
      end
`ifdef PERF_SNAPSHOT_EN
      else begin
        data = fit(shadowN[idx], d);
        err  = 1'b0;
      end
`endif
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        n[i]       = 0;
        shadowN[i] = 0;
      end
      mState = 0;
      mProto = 1'b0;
      return;
    end
`ifdef PERF_SNAPSHOT_EN
    if (snap && mState != 0) for (int i = 0; i < NCNT; i++) shadowN[i] = n[i];
`endif
    if (clear) begin
      for (int i = 0; i < NCNT; i++) n[i] = 0;
      mProto = 1'b0;
      mState = 0;
      return;
    end
    if (mState == 0) begin
      if (start) mState = 1;
    end else if (mState == 1) begin
      n[0]++;
      if (retire) n[1]++;
      for (int c = 0; c < 2; c++) begin
        if (cacheReq[c]) n[2 + 3 * c]++;
        if (cacheHit[c] && cacheReq[c]) n[3 + 3 * c]++;
        if (cacheStall[c]) n[4 + 3 * c]++;
        if (cacheHit[c] && !cacheReq[c]) mProto = 1'b1;
      end
      if (halt) mState = 2;
    end
  endtask

  task automatic tick();
    logic        expValid;
    logic [31:0] expData [3];
    logic        expErr  [3];
    logic [31:0] obsData [3];
    expValid = rd_en && rst_n;
    for (int d = 0; d < 3; d++) expRead(d, expData[d], expErr[d]);
    @(posedge clk);
    modelStep();
    #1;
    obsData[0] = rdDataA;
    obsData[1] = 32'(rdDataB);
    obsData[2] = 32'(rdDataC);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rd_valid[%0d]", d), 32'(rdValid[d]), 32'(expValid));
      if (expValid) begin
        check($sformatf("rd_data[%0d] addr %0h", d, rdAddr), obsData[d], expData[d]);
        check($sformatf("rd_err[%0d] addr %0h", d, rdAddr), 32'(rdErr[d]), 32'(expErr[d]));
      end
      check($sformatf("running[%0d]", d), 32'(runningV[d]), 32'(mState == 1));
      check($sformatf("frozen[%0d]", d), 32'(frozenV[d]), 32'(mState == 2));
      check($sformatf("proto_err[%0d]", d), 32'(protoV[d]), 32'(mProto));
      check($sformatf("ovf_any[%0d]", d), 32'(ovfV[d]), 32'(anyOvf(d)));
    end
  endtask

  task automatic readAt(input logic [5:0] addr);
    rd_en  = 1'b1;
    rdAddr = addr;
    tick();
    rd_en  = 1'b0;
  endtask

  task automatic clearThenStart();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cacheExp [6] = '{4, 3, 0, 4, 0, 0};
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; retire = 1'b0; halt = 1'b0; snap = 1'b0;
    rd_en = 1'b0; rdAddr = '0; cacheReq = '0; cacheHit = '0; cacheStall = '0;
    tick();
    tick();
    check("reset_rd_data_a", rdDataA, 32'd0);
    check("reset_rd_data_b", 32'(rdDataB), 32'd0);
    rst_n = 1'b1;

    // Cycle and instruction counting
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      tick();
    end
    retire = 1'b0;
    readAt(6'd0);
    check("plan_cycles", rdDataA, 32'd10);
    readAt(6'd1);
    check("plan_inst", rdDataA, 32'd5);

    // Cache request / hit counting
    for (int i = 0; i < 4; i++) begin
      cacheReq = 2'b11;
      cacheHit = (i < 3) ? 2'b01 : 2'b00;
      tick();
    end
    cacheReq = '0;
    cacheHit = '0;
    for (int k = 0; k < 6; k++) begin
      readAt(6'(2 + k));
      check($sformatf("plan_cache_idx%0d", 2 + k), rdDataA, 32'(cacheExp[k]));
    end

    // Halt freezes, halt cycle counted, start ignored afterwards
    clearThenStart();
    repeat (20) tick();
    halt = 1'b1;
    retire = 1'b1;
    tick();
    halt = 1'b0;
    retire = 1'b0;
    repeat (5) tick();
    readAt(6'd0);
    check("halt_cycles", rdDataA, 32'd21);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("frozen_after_start", 32'(frozenV[0]), 32'd1);

    // 4-bit overflow: saturate vs wrap
    clearThenStart();
    repeat (20) tick();
    readAt(6'd0);
    check("sat_cycles", 32'(rdDataB), 32'd15);
    check("wrap_cycles", 32'(rdDataC), 32'd4);
    check("sat_ovf", 32'(ovfV[1]), 32'd1);
    check("wrap_ovf", 32'(ovfV[2]), 32'd1);

    // Hit without request, then clear
    clearThenStart();
    cacheHit = 2'b10;
    tick();
    cacheHit = '0;
    check("proto_set", 32'(protoV[0]), 32'd1);
    readAt(6'd6);
    check("proto_hit1", rdDataA, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("proto_cleared", 32'(protoV[0]), 32'd0);
    check("idle_after_clear", 32'(runningV[0]), 32'd0);
    readAt(6'd0);
    check("cleared_cycles", rdDataA, 32'd0);
    readAt(6'd8);
    check("oor_data", rdDataA, 32'd0);
    check("oor_err", 32'(rdErr[0]), 32'd1);

    // Snapshot
    clearThenStart();
    repeat (7) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    readAt(6'h20);
`ifdef PERF_SNAPSHOT_EN
    check("snap_shadow", rdDataA, 32'd7);
`else
    check("noshadow_data", rdDataA, 32'd0);
    check("noshadow_err", 32'(rdErr[0]), 32'd1);
`endif
    readAt(6'd0);
    check("snap_live", rdDataA, 32'd10);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      clear      = ($urandom_range(0, 39) == 0);
      start      = ($urandom_range(0, 5) == 0);
      halt       = ($urandom_range(0, 29) == 0);
      retire     = 1'($urandom);
      cacheReq   = 2'($urandom);
      cacheHit   = 2'($urandom);
      cacheStall = 2'($urandom);
      snap       = ($urandom_range(0, 9) == 0);
      rd_en      = 1'($urandom);
      rdAddr     = {1'($urandom), 5'($urandom_range(0, 9))};
      tick();
    end
    rd_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Synthesizable performance-monitor block, instantiated next to the cpu core.
- Counts cycles, retired instructions and per-cache request/hit/stall events for NUM_CH caches (I-cache and D-cache at minimum).
- Freezes on halt. Counters are read through a registered read port by debug logic or the bench.
- Replaces bench-side hit/request integers with in-design hardware counters.

Parameters:
- NUM_CH, 2, number of cache channels (1..8).
- CNT_W, 32, width of every counter.
- SATURATE, 1, 1 = counters saturate at all-ones; 0 = wrap to 0.
- ADDR_W, 5, read-address width; must satisfy 2^ADDR_W >= 2+3*NUM_CH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  pulse: IDLE->RUN.
- clear  in  1  pulse: zero all counters and flags, go to IDLE.
- retire  in  1  instruction retired this cycle (RegWrite|MemWrite|halt).
- halt  in  1  halt reached writeback.
- cache_req  in  NUM_CH  per-channel request this cycle.
- cache_hit  in  NUM_CH  per-channel hit this cycle.
- cache_stall  in  NUM_CH  per-channel stall this cycle.
- snap  in  1  snapshot request (used only with PERF_SNAPSHOT_EN).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W+1  counter index; MSB selects shadow bank.
- rd_data  out  CNT_W  read data.
- rd_valid  out  1  rd_data valid.
- rd_err  out  1  address out of range (with rd_valid).
- running  out  1  state==RUN.
- frozen  out  1  state==FROZEN.
- ovf_any  out  1  OR of sticky per-counter overflow bits.
- proto_err  out  1  sticky: hit seen without req on the same channel.

Behaviour:
- Reset is synchronous on rst_n=0 at the clk edge. After reset:
  - state=IDLE;
  - all counters, shadow bank, overflow bits and proto_err = 0;
  - rd_data=0, rd_valid=0, rd_err=0.
- Counter map:
  - 0 = cycles;
  - 1 = instructions;
  - 2+3c = req[c];
  - 3+3c = hit[c];
  - 4+3c = stall[c].
- States:
  - IDLE: no counting.
  - IDLE -> RUN on start.
  - RUN: cycles +1 every clock. Each other counter +1 when its event input is high.
  - RUN -> FROZEN on halt. The halt cycle itself is counted: cycles +1, and instructions +1 if retire.
  - FROZEN: no counting. start is ignored.
- clear:
  - Any state -> IDLE.
  - Zeros counters, overflow bits and proto_err. The shadow bank is kept.
- Priority in the same cycle:
  - clear beats start and halt.
  - halt together with start while in IDLE: go to RUN; that halt is ignored.
- Hit without req on channel c (cache_hit[c]=1, cache_req[c]=0) in RUN:
  - hit[c] is not incremented;
  - proto_err is set (sticky until clear or reset).
- Overflow:
  - An increment from all-ones sets that counter's sticky ovf bit.
  - The counter then holds all-ones if SATURATE=1, or goes to 0 if SATURATE=0.
- Read port, latency 1:
  - rd_en at edge N gives rd_valid=1 and rd_data at edge N+1.
  - rd_valid is a single-cycle pulse per rd_en. Back-to-back reads are allowed, one per cycle.
  - A read returns the counter value before that cycle's increment.
- Out-of-range index (>= 2+3*NUM_CH): rd_data=0, rd_err=1, rd_valid=1.
- Read and clear in the same cycle: the read returns the pre-clear value.

Optional Feature:
- Macro: PERF_SNAPSHOT_EN.
- Defined:
  - snap in RUN or FROZEN copies all live counters into the shadow bank at that edge, using pre-increment values.
  - rd_addr MSB=1 reads the shadow bank.
  - snap coincident with clear: the snapshot captures pre-clear values.
- Not defined:
  - no shadow storage is built;
  - snap is ignored;
  - MSB=1 reads return 0 with rd_err=1.

Decomposition:
- Package perf_pkg holds:
  - counter index constants: CNT_CYCLES=0, CNT_INST=1, CNT_CH_BASE=2, CNT_PER_CH=3;
  - state enum: IDLE, RUN, FROZEN;
  - function num_counters(NUM_CH).
- One sub-module, perf_ctr_cell: a single CNT_W counter with inc, clr, SATURATE handling and sticky ovf. Instantiate it 2+3*NUM_CH times via generate.

Test Plan:
- Reset, then start. Hold 10 cycles with retire=1 every other cycle. Read idx0 and idx1 -> 10 and 5, each returned one cycle after rd_en.
- NUM_CH=2. cache_req=2'b11 for 4 cycles with cache_hit=2'b01 for 3 of them. Read idx2..7 -> req0=4, hit0=3, stall0=0, req1=4, hit1=0, stall1=0.
- Run 20 cycles, assert halt with retire=1, then run 5 more. Read idx0 -> 21; frozen=1; further start is ignored.
- CNT_W=4 with SATURATE=1: 20 cycles in RUN -> idx0=15, ovf_any=1. With SATURATE=0 -> idx0=4, ovf_any=1.
- cache_hit[1]=1 with cache_req[1]=0 -> proto_err=1 and hit1 unchanged. Pulse clear -> proto_err=0, all counters 0, state IDLE. Reading idx 8 (NUM_CH=2) -> rd_data=0, rd_err=1.
- PERF_SNAPSHOT_EN: snap at cycle count 7, run 3 more cycles. Read MSB=1 idx0 -> 7; read MSB=0 idx0 -> 10.
